mod_arith_unit: RTL

- Parametrised successor to the fixed 256-bit modular multiplier used by the ECC datapath.
- Computes (A*B) mod M, (A+B) mod M or (A−B) mod M on WIDTH-bit operands, selected per transaction.
- Sits under the point-add/point-double controller.
- Uses a single-issue in_valid/busy/out_valid handshake and flags illegal operands instead of producing garbage.

---
 rtl/mod_arith_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mod_arith_unit.sv
// Modular arithmetic unit: (A*B) mod M, (A+B) mod M or (A-B) mod M on WIDTH-bit operands.
// Latency: WIDTH cycles for MUL, 1 cycle for ADD/SUB/illegal request; then one DONE cycle.
// Backpressure: single issue; in_valid is ignored while busy=1 (no queueing, no side effects).
//
// Ports:
//   clk, rst_n      clock; asynchronous reset, active HIGH despite the name
//   in_valid        request strobe, sampled only while busy=0
//   op_sel          0=MUL, 1=ADD, 2=SUB, 3=reserved (reported as error)
//   opA, opB, opM   operands (must be < opM) and modulus (must be nonzero)
//   busy            high from the capture edge until out_valid falls
//   out_valid       one-cycle result pulse; out_data/err hold until the next completion
//   out_data, err   result; err=1 flags an illegal request and forces out_data=0
module mod_arith_unit #(
  parameter int WIDTH = 256,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       op_sel,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [WIDTH-1:0] opM,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             err
);

  localparam int AW = WIDTH + 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_MUL = 2'd0;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_RSV = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_m;
  logic             r_err;
  logic [AW-1:0]    r_acc;
  logic [CNT_W-1:0] r_cnt;

  logic             w_cap_err;
  logic [AW-1:0]    w_m_ext;
  logic [AW-1:0]    w_a_ext;
  logic [AW-1:0]    w_dbl;
  logic [AW-1:0]    w_r1;
  logic [AW-1:0]    w_add;
  logic [AW-1:0]    w_r2;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_m_ext1;
  logic [WIDTH-1:0] w_add_res;
  logic [WIDTH-1:0] w_sub_res;

  // Operand legality is judged on the raw inputs at the capture edge.
  assign w_cap_err = (opM == '0) || (opA >= opM) || (opB >= opM) || (op_sel == OP_RSV);

  // One MSB-first interleaved step. r_acc < M always holds, so 2R and R+A
  // stay below 2M and one conditional subtract keeps each partial reduced.
  // r_b is shifted left each step so its MSB is always the current bit.
  assign w_m_ext = AW'(r_m);
  assign w_a_ext = AW'(r_a);
  assign w_dbl   = r_acc << 1;
  assign w_r1    = (w_dbl >= w_m_ext) ? (w_dbl - w_m_ext) : w_dbl;
  assign w_add   = w_r1 + (r_b[WIDTH-1] ? w_a_ext : '0);
  assign w_r2    = (w_add >= w_m_ext) ? (w_add - w_m_ext) : w_add;

  // ADD keeps the carry bit so the compare against M is exact.
  assign w_m_ext1  = {1'b0, r_m};
  assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
  assign w_add_res = WIDTH'((w_sum >= w_m_ext1) ? (w_sum - w_m_ext1) : w_sum);

  // A-B wraps modulo 2^WIDTH; adding M back lands in [1, M-1] when A<B.
  assign w_sub_res = (r_a < r_b) ? (r_a - r_b + r_m) : (r_a - r_b);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_MUL;
      r_a       <= '0;
      r_b       <= '0;
      r_m       <= '0;
      r_err     <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op    <= op_sel;
            r_a     <= opA;
            r_b     <= opB;
            r_m     <= opM;
            r_err   <= w_cap_err;
            r_acc   <= '0;
            r_cnt   <= CNT_W'(WIDTH - 1);
            busy    <= 1'b1;
            r_state <= ST_CALC;
          end
        end

        ST_CALC: begin
          if (r_err) begin
            out_data  <= '0;
            err       <= 1'b1;
            out_valid <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            case (r_op)
              OP_MUL: begin
                if (r_cnt == '0) begin
                  out_data  <= WIDTH'(w_r2);
                  err       <= 1'b0;
                  out_valid <= 1'b1;
                  r_state   <= ST_DONE;
                end else begin
                  r_acc <= w_r2;
                  r_b   <= r_b << 1;
                  r_cnt <= r_cnt - CNT_W'(1);
                end
              end
              OP_ADD: begin
                out_data  <= w_add_res;
                err       <= 1'b0;
                out_valid <= 1'b1;
                r_state   <= ST_DONE;
              end
              default: begin
                // Only SUB reaches here; reserved op_sel was caught as an error.
                out_data  <= w_sub_res;
                err       <= 1'b0;
                out_valid <= 1'b1;
                r_state   <= ST_DONE;
              end
            endcase
          end
        end

        ST_DONE: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          r_state   <= ST_IDLE;
        end

        default: begin
          r_state   <= ST_IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
